spi_mem_responder: RTL
======================

Name: spi_mem_responder

Overview:
SPI mode-0 target that emulates a serial SRAM. It lets the SoC's SPI master (spi_clk/spi_mosi/spi_miso) be run against on-chip or FPGA-side memory during bring-up and verification. All SPI inputs are oversampled in the system clock domain. Incoming READ/WRITE frames are converted into single-cycle accesses on a simple synchronous memory port.

Parameters:
ADDR_WIDTH, 16, memory address width; address phase is ADDR_WIDTH/8 bytes, MSB first (must be a multiple of 8).
SYNC_STAGES, 2, synchronizer depth on spi_clk, spi_mosi and spi_cs_n.

Ports:
clk  input  1  system clock; SPI clock must be at most clk/8.
rst_n  input  1  synchronous active-low reset.
spi_cs_n  input  1  chip select, active low.
spi_clk  input  1  SPI clock, mode 0 (idle low, sample on rise, shift on fall).
spi_mosi  input  1  data from master.
spi_miso  output  1  data to master.
spi_miso_oe  output  1  high while selected (synced cs_n low).
mem_addr  output  ADDR_WIDTH  access address.
mem_wdata  output  8  write data.
mem_we  output  1  one-cycle write strobe.
mem_re  output  1  one-cycle read strobe.
mem_rdata  input  8  read data, valid exactly 1 clk after mem_re.

Behaviour:
- Reset: rst_n is sampled on the clk rising edge. On reset:
  - state=IDLE; spi_miso=0; spi_miso_oe=0; mem_we=0; mem_re=0; mem_addr=0; mem_wdata=0.
  - Bit counter and shift registers cleared.
  - Synchronizer flops preset: cs_n=1, spi_clk=0.
- Edge detection: performed on the synchronized signals.
  - rise = synced spi_clk 0->1; fall = synced spi_clk 1->0.
  - MOSI is sampled on rise, MSB first; 3-bit counter.
  - A byte completes on the 8th rise.
- States:
  - IDLE -> CMD on synced cs_n falling.
  - CMD: byte 0x03 -> ADDR (read); 0x02 -> ADDR (write); any other value -> IGNORE.
  - ADDR: ADDR_WIDTH/8 bytes are shifted into mem_addr, MSB byte first. At completion go to RD or WR.
  - RD:
    - At address completion, pulse mem_re with the assembled address.
    - Capture mem_rdata 1 clk later into the hold register.
    - Load the hold register into the TX shift register at the next fall; bit7 drives spi_miso.
    - Each subsequent fall shifts out the next bit.
    - At the 8th rise of each data byte: mem_addr increments, mem_re pulses, and the next byte is prefetched into hold, then loaded at the next fall.
  - WR:
    - At the 8th rise of each data byte: mem_wdata = byte, mem_we pulses for 1 clk with the current mem_addr.
    - The following cycle, mem_addr increments.
  - IGNORE: no memory strobes; spi_miso=0; held until cs_n deasserts.
- Address increment wraps 2^ADDR_WIDTH-1 -> 0.
- spi_miso=0 in every state except RD data phase.
- spi_miso_oe follows synced cs_n (inverted) with no added latency.
- cs_n deassert (synced rising), any state:
  - Return to IDLE next clk; bit counter cleared.
  - A partial byte is discarded: no mem_we for incomplete write bytes.
  - An in-flight mem_re read result is dropped.
  - spi_miso -> 0.
- cs_n reasserted without an intervening full deassert detection is not a new frame. The minimum cs_n high time is SYNC_STAGES+1 clk.
- mem_we and mem_re are never asserted in the same cycle.
- Each strobe is at most one cycle per byte.
- Edge and cs_n change in the same synced cycle: cs_n deassert wins.

Test Plan:
- Write frame: cs low, send 02 12 34 AA BB, cs high -> mem_we at addr 0x1234 data 0xAA, then 0x1235 data 0xBB; exactly 2 strobes.
- Read frame: memory 0x0100=0x5A, 0x0101=0xC3; send 03 01 00, then 16 clocks -> MISO yields 0x5A then 0xC3; mem_re addrs 0x0100, 0x0101, 0x0102 (prefetch).
- Wrap: write 02 FF FF 11 22 -> writes 0xFFFF=0x11, 0x0000=0x22.
- Abort: send 02 00 10 then 5 bits of a data byte, raise cs -> no mem_we; next frame 03 00 10 decodes correctly from IDLE.
- Unknown command 0x9F followed by 24 clocks -> no strobes, MISO stays 0, miso_oe=1 until cs high.
- Reset: assert rst_n=0 for 1 clk mid-read -> next clk all outputs 0, state IDLE; SPI clock at clk/8 ratio throughout passes all above.

Source files
------------

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target that emulates a serial SRAM. READ (0x03) and WRITE (0x02) frames
// are turned into single-cycle strobes on a synchronous byte-wide memory port.
module spi_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_cs_n,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata
);
  localparam int unsigned ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int unsigned ABW        = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam logic [7:0]  CMD_WRITE  = 8'h02;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_IGNORE} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] cs_sync, clk_sync, mosi_sync;
  logic                   cs_s, clk_s, mosi_s, cs_q, clk_q;
  logic                   rise, fall, cs_fall, byte_done;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift, rx_byte, tx_shift, hold;
  logic [ABW-1:0]         addr_cnt;
  logic                   is_read, rd_pend, tx_load;
  logic                   addr_shift, re_fire, we_fire, addr_inc, arm_load;

  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign clk_s       = clk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign spi_miso_oe = ~cs_s;
  assign rise        = clk_s & ~clk_q;
  assign fall        = ~clk_s & clk_q;
  assign cs_fall     = cs_q & ~cs_s;
  assign rx_byte     = {rx_shift[6:0], mosi_s};
  // A deasserted cs_n in the same synced cycle masks the byte completion.
  assign byte_done   = ~cs_s & rise & (bit_cnt == 3'd7) & (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Frame sequencing and one-cycle strobe requests.
  always_comb begin
    state_next = state;
    addr_shift = 1'b0;
    re_fire    = 1'b0;
    we_fire    = 1'b0;
    addr_inc   = 1'b0;
    arm_load   = 1'b0;
    case (state)
      S_IDLE: if (cs_fall) state_next = S_CMD;
      S_CMD: begin
        if (byte_done)
          state_next = (rx_byte == CMD_READ || rx_byte == CMD_WRITE) ? S_ADDR : S_IGNORE;
      end
      S_ADDR: begin
        if (byte_done) begin
          addr_shift = 1'b1;
          if (addr_cnt == ABW'(ADDR_BYTES - 1)) begin
            state_next = is_read ? S_RD : S_WR;
            re_fire    = is_read;
            arm_load   = is_read;
          end
        end
      end
      S_RD: begin
        if (byte_done) begin
          re_fire  = 1'b1;
          addr_inc = 1'b1;
          arm_load = 1'b1;
        end
      end
      S_WR:     if (byte_done) we_fire = 1'b1;
      S_IGNORE: state_next = S_IGNORE;
      default:  state_next = S_IDLE;
    endcase
    if (cs_s && state != S_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      clk_sync  <= '0;
      mosi_sync <= '0;
      cs_q      <= 1'b1;
      clk_q     <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'd0;
      addr_cnt  <= '0;
      is_read   <= 1'b0;
      rd_pend   <= 1'b0;
      hold      <= 8'd0;
      tx_shift  <= 8'd0;
      tx_load   <= 1'b0;
      spi_miso  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      cs_sync   <= SYNC_STAGES'({cs_sync, spi_cs_n});
      clk_sync  <= SYNC_STAGES'({clk_sync, spi_clk});
      mosi_sync <= SYNC_STAGES'({mosi_sync, spi_mosi});
      cs_q      <= cs_s;
      clk_q     <= clk_s;

      if (cs_s || state == S_IDLE) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'd0;
      end else if (rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte;
      end

      if (state == S_CMD)  addr_cnt <= '0;
      else if (addr_shift) addr_cnt <= addr_cnt + ABW'(1);

      if (state == S_CMD && byte_done) is_read <= (rx_byte == CMD_READ);

      // Write strobe cycle advances the address for the next data byte.
      if (addr_shift)              mem_addr <= (mem_addr << 8) | ADDR_WIDTH'(rx_byte);
      else if (addr_inc || mem_we) mem_addr <= mem_addr + ADDR_WIDTH'(1);

      if (we_fire) mem_wdata <= rx_byte;
      mem_we <= we_fire;
      mem_re <= re_fire;

      // Read data lands one clk after mem_re; dropped if the frame ends first.
      rd_pend <= mem_re & ~cs_s;
      if (rd_pend && !cs_s) hold <= mem_rdata;

      if (state_next != S_RD) begin
        tx_load  <= 1'b0;
        tx_shift <= 8'd0;
        spi_miso <= 1'b0;
      end else if (arm_load) begin
        tx_load <= 1'b1;
      end else if (fall) begin
        if (tx_load) begin
          spi_miso <= hold[7];
          tx_shift <= {hold[6:0], 1'b0};
          tx_load  <= 1'b0;
        end else begin
          spi_miso <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end
endmodule
